nf10_wrr_port_arbiter: RTL

Parametrised packet-boundary arbiter merging C_NUM_QUEUES AXI4-Stream slave queues onto one master stream. Supports round-robin, weighted round-robin and strict-priority modes, per-queue enable masking and per-queue granted-packet counters. Sits between the per-port RX/generator queues and the datapath, replacing the fixed five-queue arbiter. Configuration comes from the owning register block.

---
 rtl/nf10_wrr_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/nf10_wrr_port_arbiter.sv
// Packet-boundary arbiter merging C_NUM_QUEUES AXI4-Stream queues onto one master stream.
// Supports RR, weighted RR and strict priority with per-queue enables and packet counters.
module nf10_wrr_port_arbiter #(
  parameter int unsigned C_DATA_WIDTH   = 256,
  parameter int unsigned C_TUSER_WIDTH  = 128,
  parameter int unsigned C_NUM_QUEUES   = 8,
  parameter int unsigned C_WEIGHT_WIDTH = 4,
  parameter int unsigned C_CNT_WIDTH    = 16
) (
  input  logic                                     axi_aclk,
  input  logic                                     axi_areset,
  input  logic                                     sw_rst,
  input  logic [1:0]                               mode,
  input  logic [C_NUM_QUEUES-1:0]                  queue_en,
  input  logic [C_NUM_QUEUES*C_WEIGHT_WIDTH-1:0]   weight_grp,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH-1:0]     s_axis_tdata_grp,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH/8-1:0]   s_axis_tstrb_grp,
  input  logic [C_NUM_QUEUES*C_TUSER_WIDTH-1:0]    s_axis_tuser_grp,
  input  logic [C_NUM_QUEUES-1:0]                  s_axis_tvalid_grp,
  input  logic [C_NUM_QUEUES-1:0]                  s_axis_tlast_grp,
  output logic [C_NUM_QUEUES-1:0]                  s_axis_tready_grp,
  output logic [C_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]                m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic [3:0]                               cur_queue,
  output logic                                     busy,
  output logic [C_NUM_QUEUES*C_CNT_WIDTH-1:0]      pkt_cnt_grp
);

  localparam int unsigned N  = C_NUM_QUEUES;
  localparam int unsigned QW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = C_DATA_WIDTH / 8;
  localparam int unsigned WW = C_WEIGHT_WIDTH;
  localparam int unsigned CW = C_CNT_WIDTH;
  localparam logic [1:0]  MODE_WRR = 2'd1;
  localparam logic [1:0]  MODE_SP  = 2'd2;

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  state_t          r_state;
  logic [QW-1:0]   r_sel;
  logic [QW-1:0]   r_rr_ptr;
  logic [WW-1:0]   r_credit;
  logic            r_sop;
  logic [CW-1:0]   r_pkt_cnt [N];

  logic [C_DATA_WIDTH-1:0]  w_tdata  [N];
  logic [SW-1:0]            w_tstrb  [N];
  logic [C_TUSER_WIDTH-1:0] w_tuser  [N];
  logic [WW-1:0]            w_weight [N];

  for (genvar gq = 0; gq < N; gq++) begin : g_unpack
    assign w_tdata[gq]  = s_axis_tdata_grp[gq*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign w_tstrb[gq]  = s_axis_tstrb_grp[gq*SW +: SW];
    assign w_tuser[gq]  = s_axis_tuser_grp[gq*C_TUSER_WIDTH +: C_TUSER_WIDTH];
    assign w_weight[gq] = weight_grp[gq*WW +: WW];
    assign pkt_cnt_grp[gq*CW +: CW] = r_pkt_cnt[gq];
  end

  // Grant search: lowest index in strict mode, else first eligible at/after rr_ptr
  logic [N-1:0]  w_elig;
  logic          w_found;
  logic [QW-1:0] w_grant;
  int unsigned   w_idx;

  always_comb begin
    w_elig  = queue_en & s_axis_tvalid_grp;
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = (mode == MODE_SP) ? i : 32'(r_rr_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && w_elig[QW'(w_idx)]) begin
        w_found = 1'b1;
        w_grant = QW'(w_idx);
      end
    end
  end

  logic [WW-1:0] w_grant_weight;
  logic [WW-1:0] w_credit_init;
  logic [QW-1:0] w_next_ptr;
  logic          w_pkt;
  logic          w_beat_hs;
  logic          w_last_hs;
  logic          w_cont;

  assign w_grant_weight = w_weight[w_grant];
  assign w_credit_init  = (mode != MODE_WRR)        ? WW'(1) :
                          (w_grant_weight == '0)    ? WW'(1) : w_grant_weight;
  assign w_next_ptr     = (32'(w_grant) == N - 1) ? '0 : w_grant + QW'(1);
  assign w_pkt          = (r_state == ST_PKT);
  assign w_beat_hs      = w_pkt & s_axis_tvalid_grp[r_sel] & m_axis_tready;
  assign w_last_hs      = w_beat_hs & s_axis_tlast_grp[r_sel];
  // Another packet from the same queue only while WRR credit remains
  assign w_cont         = (mode == MODE_WRR) && (r_credit > WW'(1)) && queue_en[r_sel];

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_credit <= '0;
      r_sop    <= 1'b0;
      for (int unsigned q = 0; q < N; q++) r_pkt_cnt[q] <= '0;
    end else if (sw_rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_credit <= '0;
      r_sop    <= 1'b0;
      for (int unsigned q = 0; q < N; q++) r_pkt_cnt[q] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_sel    <= w_grant;
            r_credit <= w_credit_init;
            r_sop    <= 1'b1;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (w_beat_hs) r_sop <= 1'b0;
          if (w_last_hs) begin
            r_credit <= r_credit - WW'(1);
            if (w_cont) r_sop   <= 1'b1;
            else        r_state <= ST_IDLE;
          end else if (r_sop && !s_axis_tvalid_grp[r_sel]) begin
            // Queue had nothing at a packet start: give up the rest of its turn
            r_state  <= ST_IDLE;
            r_credit <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      for (int unsigned q = 0; q < N; q++) begin
        if (w_last_hs && (r_sel == QW'(q))) r_pkt_cnt[q] <= r_pkt_cnt[q] + CW'(1);
      end
    end
  end

  // Pure combinational datapath; control outputs forced low outside a packet
  assign m_axis_tdata  = w_tdata[r_sel];
  assign m_axis_tstrb  = w_tstrb[r_sel];
  assign m_axis_tuser  = w_tuser[r_sel];
  assign m_axis_tvalid = w_pkt & s_axis_tvalid_grp[r_sel];
  assign m_axis_tlast  = w_pkt & s_axis_tlast_grp[r_sel];
  assign cur_queue     = w_pkt ? 4'(r_sel) : 4'd0;
  assign busy          = w_pkt;

  always_comb begin
    s_axis_tready_grp = '0;
    if (w_pkt) s_axis_tready_grp[r_sel] = m_axis_tready;
  end

endmodule
